// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit processor core, its ALU and the program loader.
package proc_pkg;

  localparam int INSTR_W  = 8;
  localparam int ADDR_W   = 4;
  localparam int PM_DEPTH = 16;

  // Loader sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    HALTED = 3'd4
  } state_t;

  // Opcode field values, instr[7:4]
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[7:4];
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot/run sequencer: streams a program into core memory, then releases the
// core from PC reset and stops it on halt request or run-cycle timeout.
//
// state  | meaning
// IDLE   | no activity, core held in PC reset
// LOAD   | accepting program words, one pm write per accepted word
// START  | one cycle of PC reset with run counter cleared
// RUN    | core executing, run counter counting
// HALTED | core stopped and held at PC 0, program still resident
module prog_loader
  import proc_pkg::*;
#(
  parameter int MAX_RUN = 255,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  input  logic               run_req,
  input  logic               halt_req,
  input  logic               ld_valid,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               pm_we,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [INSTR_W-1:0] pm_wdata,
  output logic               core_reset,
  output logic               busy,
  output logic               loaded,
  output logic               timeout,
  output logic [ADDR_W:0]    word_count
);

  localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W+1)'(PM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  RUN_LIMIT = CNT_W'(MAX_RUN);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

  state_t           state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;

  // Saturating next value of the run counter
  always_comb begin
    cnt_next = run_cnt;
    if (run_cnt != CNT_SAT) cnt_next = run_cnt + 1'b1;
  end

  assign accept = ld_valid && ld_ready;

  // Sequencer FSM with registered outputs; pm_we is a one-cycle strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      run_cnt    <= '0;
      ld_ready   <= 1'b0;
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_wdata   <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      loaded     <= 1'b0;
      timeout    <= 1'b0;
      word_count <= '0;
    end else begin
      pm_we <= 1'b0;
      case (state)
        IDLE, HALTED: begin
          if (load_req) begin
            state      <= LOAD;
            loaded     <= 1'b0;
            word_count <= '0;
            ld_ready   <= 1'b1;
            busy       <= 1'b1;
          end else if (run_req && loaded) begin
            state   <= START;
            timeout <= 1'b0;
            run_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          // A word handshaken in the abort cycle was already accepted, so it is still written
          if (accept) begin
            pm_we      <= 1'b1;
            pm_addr    <= word_count[ADDR_W-1:0];
            pm_wdata   <= ld_data;
            word_count <= word_count + 1'b1;
          end
          if (halt_req) begin
            state    <= IDLE;
            ld_ready <= 1'b0;
            busy     <= 1'b0;
            loaded   <= 1'b0;
          end else if (accept && (ld_last || word_count == LAST_WORD)) begin
            state    <= IDLE;
            ld_ready <= 1'b0;
            busy     <= 1'b0;
            loaded   <= 1'b1;
          end
        end
        START: begin
          run_cnt    <= '0;
          state      <= RUN;
          core_reset <= 1'b0;
        end
        RUN: begin
          run_cnt <= cnt_next;
          // Halt takes precedence so a simultaneous expiry is not reported as a timeout
          if (halt_req) begin
            state      <= HALTED;
            core_reset <= 1'b1;
            busy       <= 1'b0;
          end else if (MAX_RUN != 0 && cnt_next == RUN_LIMIT) begin
            state      <= HALTED;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            timeout    <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          core_reset <= 1'b1;
          busy       <= 1'b0;
          ld_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader, run with a 10-cycle run timeout.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_req = 1'b0, run_req = 1'b0, halt_req = 1'b0;
  logic       ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_ready, pm_we, core_reset, busy, loaded, timeout;
  logic [3:0] pm_addr;
  logic [7:0] pm_wdata;
  logic [4:0] word_count;

  int checks = 0;
  int errors = 0;

  prog_loader #(.MAX_RUN(10), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .run_req(run_req), .halt_req(halt_req),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .core_reset(core_reset),
    .busy(busy), .loaded(loaded), .timeout(timeout), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (ld_ready !== 1'b0)   begin errors++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    checks++; if (pm_we !== 1'b0)      begin errors++; $display("FAIL reset_pm_we: got %b want 0", pm_we); end
    checks++; if (pm_addr !== 4'h0)    begin errors++; $display("FAIL reset_pm_addr: got %h want 0", pm_addr); end
    checks++; if (pm_wdata !== 8'h00)  begin errors++; $display("FAIL reset_pm_wdata: got %h want 00", pm_wdata); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (loaded !== 1'b0)     begin errors++; $display("FAIL reset_loaded: got %b want 0", loaded); end
    checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    checks++; if (word_count !== 5'd0) begin errors++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    reset = 1'b0;
    tick();
  endtask

  // 16 words back-to-back without ld_last: load ends on the PM_DEPTH-th word
  task automatic test_full_load();
    load_req = 1'b1; tick(); load_req = 1'b0;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL full_ready_start: got %b want 1", ld_ready); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL full_busy: got %b want 1", busy); end
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1; ld_data = 8'h60 + 8'(i);
      tick();
      checks++; if (pm_we !== 1'b1)           begin errors++; $display("FAIL full_we[%0d]: got %b want 1", i, pm_we); end
      checks++; if (pm_addr !== 4'(i))        begin errors++; $display("FAIL full_addr[%0d]: got %0d want %0d", i, pm_addr, i); end
      checks++; if (pm_wdata !== 8'h60 + 8'(i)) begin errors++; $display("FAIL full_data[%0d]: got %h want %h", i, pm_wdata, 8'h60 + 8'(i)); end
    end
    ld_valid = 1'b0;
    checks++; if (ld_ready !== 1'b0)    begin errors++; $display("FAIL full_ready_end: got %b want 0", ld_ready); end
    checks++; if (loaded !== 1'b1)      begin errors++; $display("FAIL full_loaded: got %b want 1", loaded); end
    checks++; if (word_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", word_count); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL full_idle: got %b want 0", busy); end
    tick();
    checks++; if (pm_we !== 1'b0)       begin errors++; $display("FAIL full_we_after: got %b want 0", pm_we); end
  endtask

  // Short program with ld_last, then run: START lasts one cycle
  task automatic test_last_and_run();
    logic [7:0] prog [3];
    prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33;
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 2);
      tick();
      checks++; if (pm_addr !== 4'(i) || pm_wdata !== prog[i]) begin errors++; $display("FAIL last_write[%0d]: got %0d/%h want %0d/%h", i, pm_addr, pm_wdata, i, prog[i]); end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    checks++; if (word_count !== 5'd3) begin errors++; $display("FAIL last_count: got %0d want 3", word_count); end
    checks++; if (loaded !== 1'b1 || ld_ready !== 1'b0) begin errors++; $display("FAIL last_done: got loaded=%b ready=%b want 1/0", loaded, ld_ready); end
    run_req = 1'b1; tick(); run_req = 1'b0;
    checks++; if (core_reset !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL start_cycle: got cr=%b busy=%b want 1/1", core_reset, busy); end
    tick();
    checks++; if (core_reset !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL run_entry: got cr=%b busy=%b want 0/1", core_reset, busy); end
    tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    checks++; if (core_reset !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL halt_run: got cr=%b busy=%b to=%b want 1/0/0", core_reset, busy, timeout); end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL halt_keeps_loaded: got %b want 1", loaded); end
  endtask

  // Run from HALTED to expiry; measure cycles with core_reset low
  task automatic test_timeout();
    int n = 0;
    bit done = 0;
    run_req = 1'b1; tick(); run_req = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      tick();
      if (core_reset === 1'b0) n++; else done = 1;
    end
    checks++; if (!done) begin errors++; $display("FAIL timeout_bound: got still running want halted"); end
    checks++; if (n !== 10) begin errors++; $display("FAIL timeout_cycles: got %0d want 10", n); end
    checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_flag: got to=%b busy=%b want 1/0", timeout, busy); end
    // Rerun clears timeout; halt coincident with expiry reports no timeout
    run_req = 1'b1; tick(); run_req = 1'b0;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timeout); end
    for (int k = 0; k < 10; k++) tick();
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL coincide_pre: got cr=%b want 0", core_reset); end
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    checks++; if (core_reset !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL coincide_halt: got cr=%b to=%b want 1/0", core_reset, timeout); end
  endtask

  // Abort a load after two words; a later run_req must be ignored
  task automatic test_abort();
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 8'h90 + 8'(i); tick();
    end
    ld_valid = 1'b0;
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    checks++; if (busy !== 1'b0 || loaded !== 1'b0 || ld_ready !== 1'b0) begin errors++; $display("FAIL abort_state: got busy=%b loaded=%b ready=%b want 0/0/0", busy, loaded, ld_ready); end
    checks++; if (word_count !== 5'd2) begin errors++; $display("FAIL abort_count: got %0d want 2", word_count); end
    run_req = 1'b1; tick(); run_req = 1'b0;
    checks++; if (busy !== 1'b0 || core_reset !== 1'b1) begin errors++; $display("FAIL abort_run_ignored: got busy=%b cr=%b want 0/1", busy, core_reset); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_run_ignored2: got %b want 0", busy); end
  endtask

  // ld_valid toggling 1-0-1-0: writes only for accepted words, contiguous addresses
  task automatic test_throttle();
    int k = 0;
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = (i % 2 == 0); ld_data = 8'hA0 + 8'(i); ld_last = (i == 6);
      tick();
      if (i % 2 == 0) begin
        checks++; if (pm_we !== 1'b1 || pm_addr !== 4'(k) || pm_wdata !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL throttle_write[%0d]: got we=%b %0d/%h want 1 %0d/%h", i, pm_we, pm_addr, pm_wdata, k, 8'hA0 + 8'(i)); end
        k++;
      end else begin
        checks++; if (pm_we !== 1'b0) begin errors++; $display("FAIL throttle_gap[%0d]: got %b want 0", i, pm_we); end
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    checks++; if (word_count !== 5'd4 || loaded !== 1'b1) begin errors++; $display("FAIL throttle_done: got cnt=%0d loaded=%b want 4/1", word_count, loaded); end
  endtask

  // load_req and run_req together: load wins
  task automatic test_priority();
    load_req = 1'b1; run_req = 1'b1; tick(); load_req = 1'b0; run_req = 1'b0;
    checks++; if (ld_ready !== 1'b1 || loaded !== 1'b0 || core_reset !== 1'b1) begin errors++; $display("FAIL load_wins: got ready=%b loaded=%b cr=%b want 1/0/1", ld_ready, loaded, core_reset); end
    ld_valid = 1'b1; ld_data = 8'h5A; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    checks++; if (loaded !== 1'b1 || word_count !== 5'd1) begin errors++; $display("FAIL load_wins_done: got loaded=%b cnt=%0d want 1/1", loaded, word_count); end
  endtask

  // Async reset during RUN and during LOAD
  task automatic test_async_reset();
    run_req = 1'b1; tick(); run_req = 1'b0;
    tick(); tick();
    reset = 1'b1; #1;
    checks++; if (core_reset !== 1'b1 || busy !== 1'b0 || loaded !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rst_run: got cr=%b busy=%b loaded=%b to=%b want 1/0/0/0", core_reset, busy, loaded, timeout); end
    checks++; if (word_count !== 5'd0 || pm_addr !== 4'h0 || pm_wdata !== 8'h00) begin errors++; $display("FAIL rst_run_regs: got %0d/%h/%h want 0/0/00", word_count, pm_addr, pm_wdata); end
    #2; reset = 1'b0;
    tick();
    load_req = 1'b1; tick(); load_req = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hC3; tick();
    checks++; if (pm_we !== 1'b1) begin errors++; $display("FAIL rst_load_pre: got %b want 1", pm_we); end
    reset = 1'b1; #1;
    checks++; if (ld_ready !== 1'b0 || pm_we !== 1'b0 || busy !== 1'b0 || pm_addr !== 4'h0 || pm_wdata !== 8'h00 || word_count !== 5'd0) begin errors++; $display("FAIL rst_load: got ready=%b we=%b busy=%b addr=%h data=%h cnt=%0d want 0/0/0/0/00/0", ld_ready, pm_we, busy, pm_addr, pm_wdata, word_count); end
    ld_valid = 1'b0;
    #2; reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_last_and_run();
    test_timeout();
    test_abort();
    test_throttle();
    test_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
